// File: rtl/leaf_line_unpacker.sv
// Fetches memory lines into a 2-entry buffer and unpacks them, lowest record first, into a leaf FIFO.
// Records reach o_data one cycle after a line returns; i_fifo_full stalls the unpacker and, through the buffer, new requests.
module leaf_line_unpacker #(
    parameter int DATA_WIDTH = 128,
    parameter int LINE_WIDTH = 512,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [LEN_WIDTH-1:0]  i_num_records,
    output logic                  o_req_valid,
    output logic [ADDR_WIDTH-1:0] o_req_addr,
    input  logic                  i_req_ready,
    input  logic                  i_line_valid,
    input  logic [LINE_WIDTH-1:0] i_line,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_write,
    input  logic                  i_fifo_full,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);
    localparam int RPL   = LINE_WIDTH / DATA_WIDTH;
    localparam int PTR_W = (RPL > 1) ? $clog2(RPL) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_nxt;
    logic [LEN_WIDTH-1:0]  lines_rem;
    logic [LEN_WIDTH-1:0]  start_lines;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [1:0]            outstanding;
    logic [1:0]            count;
    logic                  head;
    logic                  tail;
    logic [PTR_W-1:0]      ptr;
    logic [LINE_WIDTH-1:0] line_buf [2];
    logic                  err;
    logic                  req_fire;
    logic                  line_ok;
    logic                  head_free;
    logic [2:0]            inflight;

    assign start_lines = i_num_records / LEN_WIDTH'(RPL);
    assign inflight    = {1'b0, outstanding} + {1'b0, count};
    assign o_req_valid = (state == RUN) && (lines_rem != '0) && (inflight < 3'd2);
    assign o_req_addr  = req_addr;
    assign req_fire    = o_req_valid && i_req_ready;
    assign line_ok     = i_line_valid && (outstanding != 2'd0);
    assign o_write     = (count != 2'd0) && !i_fifo_full;
    assign head_free   = o_write && (ptr == PTR_W'(RPL - 1));
    assign o_data      = line_buf[head][ptr*DATA_WIDTH +: DATA_WIDTH];
    assign o_busy      = (state != IDLE);
    assign o_done      = (state == DONE);
    assign o_err       = err;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_start) state_nxt = (start_lines == '0) ? DONE : RUN;
            // Last record leaves when the final line is freed with nothing else pending.
            RUN:  if (head_free && count == 2'd1 && lines_rem == '0 && outstanding == 2'd0)
                      state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            lines_rem   <= '0;
            req_addr    <= '0;
            outstanding <= 2'd0;
            count       <= 2'd0;
            head        <= 1'b0;
            tail        <= 1'b0;
            ptr         <= '0;
            err         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && i_start) begin
                req_addr  <= i_base_addr;
                lines_rem <= start_lines;
            end else if (req_fire) begin
                req_addr  <= req_addr + ADDR_WIDTH'(RPL);
                lines_rem <= lines_rem - 1'b1;
            end
            case ({req_fire, line_ok})
                2'b10:   outstanding <= outstanding + 2'd1;
                2'b01:   outstanding <= outstanding - 2'd1;
                default: ;
            endcase
            case ({line_ok, head_free})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
            if (line_ok)
                tail <= ~tail;
            if (head_free)
                head <= ~head;
            if (o_write)
                ptr <= (ptr == PTR_W'(RPL - 1)) ? '0 : ptr + 1'b1;
            if (i_line_valid && outstanding == 2'd0)
                err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            line_buf[0] <= '0;
            line_buf[1] <= '0;
        end else if (line_ok) begin
            line_buf[tail] <= i_line;
        end
    end
endmodule

// File: tb/tb_leaf_line_unpacker.sv
// Directed bench for leaf_line_unpacker: a delayed-return memory model and a record scoreboard.
module tb_leaf_line_unpacker;
    localparam int DW  = 128;
    localparam int LW  = 512;
    localparam int AW  = 32;
    localparam int NW  = 32;
    localparam int LAT = 2;

    logic          i_clk, i_rst, i_start;
    logic [AW-1:0] i_base_addr;
    logic [NW-1:0] i_num_records;
    logic          o_req_valid;
    logic [AW-1:0] o_req_addr;
    logic          i_req_ready;
    logic          i_line_valid;
    logic [LW-1:0] i_line;
    logic [DW-1:0] o_data;
    logic          o_write, i_fifo_full, o_busy, o_done, o_err;

    logic          resp_vld, inj_vld;
    logic [LW-1:0] resp_line, inj_line;
    assign i_line_valid = resp_vld | inj_vld;
    assign i_line       = inj_vld ? inj_line : resp_line;

    leaf_line_unpacker #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .LEN_WIDTH(NW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_num_records(i_num_records), .o_req_valid(o_req_valid), .o_req_addr(o_req_addr),
        .i_req_ready(i_req_ready), .i_line_valid(i_line_valid), .i_line(i_line),
        .o_data(o_data), .o_write(o_write), .i_fifo_full(i_fifo_full), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0, done_cyc = 0, busy_cnt = 0, wr_total = 0;
    int acc_lines = 0, run_wr = 0, st_cyc = 0;
    logic [DW-1:0] sb_q [$];
    logic [AW-1:0] req_log [$];
    logic [AW-1:0] rq_addr [$];
    int            rq_due  [$];

    function automatic logic [DW-1:0] rec(input logic [AW-1:0] x);
        return {x, ~x, x ^ 32'h5a5a_5a5a, x + 32'h1234_5678};
    endfunction

    function automatic logic [LW-1:0] mk_line(input logic [AW-1:0] a);
        logic [LW-1:0] l;
        for (int k = 0; k < LW / DW; k++)
            l[k*DW +: DW] = rec(a + AW'(k));
        return l;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Memory model: returns each accepted request's line LAT cycles after it was seen.
    initial begin
        logic [AW-1:0] a;
        resp_vld  = 1'b0;
        resp_line = '0;
        forever begin
            @(posedge i_clk);
            #1;
            if (i_rst) begin
                rq_addr.delete();
                rq_due.delete();
                resp_vld = 1'b0;
            end else if (rq_addr.size() != 0 && rq_due[0] <= cyc + 1) begin
                a = rq_addr.pop_front();
                void'(rq_due.pop_front());
                resp_line = mk_line(a);
                resp_vld  = 1'b1;
            end else begin
                resp_vld = 1'b0;
            end
        end
    end

    // Monitor: request log, in-flight bound, request hold, record scoreboard.
    initial begin
        logic          prev_vld, prev_rdy;
        logic [AW-1:0] prev_addr;
        logic [DW-1:0] e;
        prev_vld = 1'b0; prev_rdy = 1'b0; prev_addr = '0;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (i_rst) begin
                acc_lines = 0;
                run_wr    = 0;
                prev_vld  = 1'b0;
            end else begin
                if (prev_vld && !prev_rdy) begin
                    check("req_vld_hold", o_req_valid, 1);
                    check("req_addr_hold", o_req_addr, prev_addr);
                end
                if (o_req_valid && i_req_ready) begin
                    req_log.push_back(o_req_addr);
                    rq_addr.push_back(o_req_addr);
                    rq_due.push_back(cyc + LAT);
                    acc_lines++;
                    check("inflight_le2", acc_lines <= 2 + run_wr / 4, 1);
                end
                if (o_write) begin
                    if (sb_q.size() == 0) begin
                        check("extra_write", o_data, 0);
                        check("extra_write_strobe", o_write, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("wr_data", o_data, e);
                    end
                    wr_total++;
                    run_wr++;
                end
                if (o_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (o_busy) busy_cnt++;
                prev_vld  = o_req_valid;
                prev_rdy  = i_req_ready;
                prev_addr = o_req_addr;
            end
        end
    end

    task automatic start_seq(input logic [AW-1:0] b, input int n);
        for (int i = 0; i < n; i++)
            sb_q.push_back(rec(b + AW'(i)));
        req_log.delete();
        step();
        i_base_addr   = b;
        i_num_records = NW'(n);
        i_start       = 1'b1;
        st_cyc        = cyc + 1;
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_cnt != d0) break;
        end
        check("done_timeout", done_cnt != d0, 1);
    endtask

    task automatic wait_writes(input int w0, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (wr_total - w0 >= n) break;
            step();
        end
        check("write_timeout", wr_total - w0 >= n, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, o_req_valid, 0);
        check({tag, "_req_addr"},  o_req_addr, 0);
        check({tag, "_write"},     o_write, 0);
        check({tag, "_data"},      o_data, 0);
        check({tag, "_busy"},      o_busy, 0);
        check({tag, "_done"},      o_done, 0);
        check({tag, "_err"},       o_err, 0);
    endtask

    initial begin
        int d0, w0, b0;
        i_rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_num_records = '0;
        i_req_ready = 1'b1; i_fifo_full = 1'b0; inj_vld = 1'b0; inj_line = '0;
        #2;
        check_reset_outputs("rst");
        repeat (3) step();
        #1 i_rst = 1'b0;

        // Basic sequence: four lines at 32..44, records in order.
        d0 = done_cnt; w0 = wr_total;
        start_seq(32, 16);
        wait_done(200);
        repeat (3) step();
        check("basic_done_once", done_cnt - d0, 1);
        check("basic_writes", wr_total - w0, 16);
        check("basic_sb_empty", sb_q.size(), 0);
        check("basic_req_count", req_log.size(), 4);
        for (int i = 0; i < 4 && i < req_log.size(); i++)
            check("basic_req_addr", req_log[i], 32 + 4 * i);
        check("basic_err", o_err, 0);

        // Zero-length sequence.
        d0 = done_cnt; b0 = busy_cnt;
        start_seq(500, 0);
        wait_done(10);
        repeat (3) step();
        check("zero_done_once", done_cnt - d0, 1);
        check("zero_busy_cycles", busy_cnt - b0, 1);
        check("zero_no_req", req_log.size(), 0);
        check("zero_done_timing", (done_cyc - st_cyc >= 1) && (done_cyc - st_cyc <= 2), 1);

        // FIFO full for 5 cycles in the middle of the first line.
        w0 = wr_total;
        start_seq(8, 16);
        wait_writes(w0, 2, 200);
        i_fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check("full_no_write", o_write, 0);
            if (sb_q.size() != 0) check("full_data_hold", o_data, sb_q[0]);
        end
        step();
        i_fifo_full = 1'b0;
        wait_done(200);
        check("full_writes", wr_total - w0, 16);
        check("full_sb_empty", sb_q.size(), 0);

        // Request channel stalled for 10 cycles.
        w0 = wr_total;
        i_req_ready = 1'b0;
        start_seq(64, 16);
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            check("stall_req_valid", o_req_valid, 1);
            check("stall_req_addr", o_req_addr, 64);
        end
        step();
        i_req_ready = 1'b1;
        wait_done(200);
        check("stall_writes", wr_total - w0, 16);
        check("stall_sb_empty", sb_q.size(), 0);

        // Unsolicited line while idle.
        step();
        inj_line = mk_line(999);
        inj_vld  = 1'b1;
        @(negedge i_clk);
        check("unsol_no_write", o_write, 0);
        step();
        inj_vld = 1'b0;
        @(negedge i_clk);
        check("unsol_err_set", o_err, 1);
        check("unsol_idle", o_busy, 0);
        w0 = wr_total;
        start_seq(100, 8);
        wait_done(200);
        check("unsol_writes", wr_total - w0, 8);
        check("unsol_sb_empty", sb_q.size(), 0);
        check("unsol_err_sticky", o_err, 1);

        // Reset in the middle of a sequence, then a fresh run.
        w0 = wr_total;
        start_seq(200, 16);
        wait_writes(w0, 6, 200);
        #2 i_rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        sb_q.delete();
        @(posedge i_clk);
        #2 i_rst = 1'b0;
        d0 = done_cnt; w0 = wr_total;
        start_seq(0, 8);
        wait_done(200);
        repeat (3) step();
        check("post_rst_writes", wr_total - w0, 8);
        check("post_rst_done", done_cnt - d0, 1);
        check("post_rst_sb_empty", sb_q.size(), 0);
        check("post_rst_err", o_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
